// File: rtl/vm_selection_inventory.sv
// vm_selection_inventory: keypad selection against a per-slot price/stock table, held until vend done/abort.
// Optional HOLD timeout enabled by defining VM_SEL_TIMEOUT_EN.
module vm_selection_inventory #(
    parameter int ROWS           = 6,
    parameter int COLS           = 6,
    parameter int PRICE_W        = 12,
    parameter int STOCK_W        = 4,
    parameter int INIT_STOCK     = 5,
    parameter int DEFAULT_PRICE  = 250,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         row,
    input  logic [3:0]         col,
    input  logic               enter_key,
    input  logic               vend_done,
    input  logic               vend_abort,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_row,
    input  logic [3:0]         cfg_col,
    input  logic [PRICE_W-1:0] cfg_price,
    input  logic [STOCK_W-1:0] cfg_stock,
    output logic               item_selection_valid,
    output logic [3:0]         dispense_row,
    output logic [3:0]         dispense_col,
    output logic [PRICE_W-1:0] item_price,
    output logic               dispense_pulse,
    output logic               sel_error,
    output logic [1:0]         error_code,
    output logic               busy
);
    localparam int N = ROWS * COLS;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] R4 = 4'(ROWS);
    localparam logic [3:0] C4 = 4'(COLS);
    localparam logic [7:0] C8 = 8'(COLS);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t state, state_n;
    logic [PRICE_W-1:0] price_mem [0:N-1];
    logic [STOCK_W-1:0] stock_mem [0:N-1];
    logic [AW-1:0] hold_a, hold_a_n, sel_a, cfg_a;
    logic sel_ok, cfg_ok, wr, dec, timeout;
    logic valid_n, pulse_n, err_n;
    logic [3:0] row_n, col_n;
    logic [PRICE_W-1:0] price_n;
    logic [1:0] code_n;

    function automatic logic addr_ok(input logic [3:0] r, input logic [3:0] c);
        return r != 4'd0 && r <= R4 && c != 4'd0 && c <= C4;
    endfunction

    function automatic logic [AW-1:0] addr(input logic [3:0] r, input logic [3:0] c);
        logic [7:0] i;
        i = ({4'd0, r} - 8'd1) * C8 + {4'd0, c} - 8'd1;
        return i[AW-1:0];
    endfunction

    assign sel_ok = addr_ok(row, col);
    assign cfg_ok = addr_ok(cfg_row, cfg_col);
    assign sel_a  = addr(row, col);
    assign cfg_a  = addr(cfg_row, cfg_col);
    assign busy   = state == HOLD;

`ifdef VM_SEL_TIMEOUT_EN
    logic [31:0] cnt;
    always_ff @(posedge clk) begin
        if (reset || state != HOLD)
            cnt <= '0;
        else
            cnt <= cnt + 32'd1;
    end
    assign timeout = state == HOLD && cnt == 32'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        valid_n  = item_selection_valid;
        row_n    = dispense_row;
        col_n    = dispense_col;
        price_n  = item_price;
        hold_a_n = hold_a;
        pulse_n  = 1'b0;
        err_n    = 1'b0;
        code_n   = 2'b00;
        wr       = 1'b0;
        dec      = 1'b0;
        if (state == IDLE) begin
            if (cfg_we)
                wr = cfg_ok;
            else if (enter_key) begin
                if (!sel_ok)
                    {err_n, code_n} = 3'b101;
                else if (stock_mem[sel_a] == '0)
                    {err_n, code_n} = 3'b110;
                else begin
                    state_n  = HOLD;
                    valid_n  = 1'b1;
                    row_n    = row;
                    col_n    = col;
                    price_n  = price_mem[sel_a];
                    hold_a_n = sel_a;
                end
            end
        end else if (vend_done || vend_abort || timeout) begin
            state_n = IDLE;
            valid_n = 1'b0;
            row_n   = 4'd0;
            col_n   = 4'd0;
            price_n = '0;
            dec     = vend_done;
            pulse_n = vend_done;
            if (!vend_done && !vend_abort)
                {err_n, code_n} = 3'b111;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            item_selection_valid <= 1'b0;
            dispense_row         <= 4'd0;
            dispense_col         <= 4'd0;
            item_price           <= '0;
            dispense_pulse       <= 1'b0;
            sel_error            <= 1'b0;
            error_code           <= 2'b00;
            hold_a               <= '0;
            for (int i = 0; i < N; i++) begin
                price_mem[AW'(i)] <= PRICE_W'(DEFAULT_PRICE);
                stock_mem[AW'(i)] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            state                <= state_n;
            item_selection_valid <= valid_n;
            dispense_row         <= row_n;
            dispense_col         <= col_n;
            item_price           <= price_n;
            dispense_pulse       <= pulse_n;
            sel_error            <= err_n;
            error_code           <= code_n;
            hold_a               <= hold_a_n;
            if (wr) begin
                price_mem[cfg_a] <= cfg_price;
                stock_mem[cfg_a] <= cfg_stock;
            end
            // decrement saturates at zero
            if (dec && stock_mem[hold_a] != '0)
                stock_mem[hold_a] <= stock_mem[hold_a] - 1'b1;
        end
    end
endmodule

// File: tb/tb_vm_selection_inventory.sv
// tb_vm_selection_inventory: directed scenario tests for vm_selection_inventory (default build).
module tb_vm_selection_inventory;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row = 4'd0, col = 4'd0, cfg_row = 4'd0, cfg_col = 4'd0;
    logic        enter_key = 1'b0, vend_done = 1'b0, vend_abort = 1'b0, cfg_we = 1'b0;
    logic [11:0] cfg_price = 12'd0;
    logic [3:0]  cfg_stock = 4'd0;
    logic        item_selection_valid, dispense_pulse, sel_error, busy;
    logic [3:0]  dispense_row, dispense_col;
    logic [11:0] item_price;
    logic [1:0]  error_code;
    int tests = 0;
    int fails = 0;

    vm_selection_inventory dut (
        .clk(clk), .reset(reset), .row(row), .col(col), .enter_key(enter_key),
        .vend_done(vend_done), .vend_abort(vend_abort), .cfg_we(cfg_we),
        .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_price(cfg_price), .cfg_stock(cfg_stock),
        .item_selection_valid(item_selection_valid), .dispense_row(dispense_row),
        .dispense_col(dispense_col), .item_price(item_price), .dispense_pulse(dispense_pulse),
        .sel_error(sel_error), .error_code(error_code), .busy(busy)
    );

    always #5 clk = ~clk;

    // {valid, busy, row, col, price}
    wire [21:0] held = {item_selection_valid, busy, dispense_row, dispense_col, item_price};
    // {valid, busy, pulse, err, code}
    wire [5:0]  flags = {item_selection_valid, busy, dispense_pulse, sel_error, error_code};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] r, input logic [3:0] c);
        row = r;
        col = c;
        enter_key = 1'b1;
        tick();
        enter_key = 1'b0;
    endtask

    task automatic done_vend;
        vend_done = 1'b1;
        tick();
        vend_done = 1'b0;
    endtask

    task automatic abort_vend;
        vend_abort = 1'b1;
        tick();
        vend_abort = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        tests++;
        if ({held, flags} !== 28'd0) begin
            fails++;
            $display("FAIL reset_outputs got held=%h flags=%b exp all 0", held, flags);
        end
    endtask

    task automatic test_select_vend;
        press(4'd2, 4'd3);
        tests++;
        if (held !== {1'b1, 1'b1, 4'd2, 4'd3, 12'd250}) begin
            fails++;
            $display("FAIL select_2_3 got %h exp %h", held, {1'b1, 1'b1, 4'd2, 4'd3, 12'd250});
        end
        done_vend();
        tests++;
        if ({held, flags} !== {22'd0, 6'b001000}) begin
            fails++;
            $display("FAIL vend_done_pulse got held=%h flags=%b exp held=0 flags=001000", held, flags);
        end
        tick();
        tests++;
        if (dispense_pulse !== 1'b0) begin
            fails++;
            $display("FAIL pulse_one_cycle got %b exp 0", dispense_pulse);
        end
    endtask

    // n successful vends on (r,c), then the slot must report sold out
    task automatic drain(input logic [3:0] r, input logic [3:0] c, input int n, input string nm);
        int ok = 0;
        for (int i = 0; i < n; i++) begin
            press(r, c);
            if (item_selection_valid === 1'b1) ok++;
            done_vend();
        end
        tests++;
        if (ok !== n) begin
            fails++;
            $display("FAIL %s_vends got %0d exp %0d", nm, ok, n);
        end
        press(r, c);
        tests++;
        if (flags !== 6'b000110) begin
            fails++;
            $display("FAIL %s_soldout got flags=%b exp 000110", nm, flags);
        end
        tick();
    endtask

    task automatic test_stock_depletion;
        drain(4'd2, 4'd3, 4, "stock_2_3");
    endtask

    task automatic test_cfg_soldout;
        cfg_row = 4'd1; cfg_col = 4'd1; cfg_price = 12'd710; cfg_stock = 4'd1; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        press(4'd1, 4'd1);
        tests++;
        if (held !== {1'b1, 1'b1, 4'd1, 4'd1, 12'd710}) begin
            fails++;
            $display("FAIL cfg_price_1_1 got %h exp %h", held, {1'b1, 1'b1, 4'd1, 4'd1, 12'd710});
        end
        done_vend();
        press(4'd1, 4'd1);
        tests++;
        if ({held, flags} !== {22'd0, 6'b000110}) begin
            fails++;
            $display("FAIL cfg_soldout got held=%h flags=%b exp 0/000110", held, flags);
        end
        tick();
        tests++;
        if (sel_error !== 1'b0) begin
            fails++;
            $display("FAIL err_one_cycle got %b exp 0", sel_error);
        end
        cfg_row = 4'd3; cfg_col = 4'd3; cfg_price = 12'd99; cfg_stock = 4'd2; cfg_we = 1'b1;
        row = 4'd3; col = 4'd3; enter_key = 1'b1;
        tick();
        cfg_we = 1'b0; enter_key = 1'b0;
        tests++;
        if (flags !== 6'b000000) begin
            fails++;
            $display("FAIL cfg_priority got flags=%b exp 000000", flags);
        end
        press(4'd3, 4'd3);
        tests++;
        if (held !== {1'b1, 1'b1, 4'd3, 4'd3, 12'd99}) begin
            fails++;
            $display("FAIL cfg_price_3_3 got %h exp %h", held, {1'b1, 1'b1, 4'd3, 4'd3, 12'd99});
        end
        abort_vend();
    endtask

    task automatic test_bad_addr;
        logic [7:0] vec [3] = '{8'h02, 8'h71, 8'h17};
        for (int i = 0; i < 3; i++) begin
            press(vec[i][7:4], vec[i][3:0]);
            tests++;
            if ({held, flags} !== {22'd0, 6'b000101}) begin
                fails++;
                $display("FAIL bad_addr_%h got held=%h flags=%b exp 0/000101", vec[i], held, flags);
            end
            tick();
        end
        press(4'd6, 4'd6);
        tests++;
        if (held !== {1'b1, 1'b1, 4'd6, 4'd6, 12'd250}) begin
            fails++;
            $display("FAIL corner_6_6 got %h exp %h", held, {1'b1, 1'b1, 4'd6, 4'd6, 12'd250});
        end
        abort_vend();
    endtask

    task automatic test_done_abort;
        press(4'd4, 4'd4);
        vend_done = 1'b1; vend_abort = 1'b1;
        tick();
        vend_done = 1'b0; vend_abort = 1'b0;
        tests++;
        if (flags !== 6'b001000) begin
            fails++;
            $display("FAIL done_wins got flags=%b exp 001000", flags);
        end
        press(4'd4, 4'd4);
        abort_vend();
        tests++;
        if ({held, flags} !== 28'd0) begin
            fails++;
            $display("FAIL abort_only got held=%h flags=%b exp 0", held, flags);
        end
        drain(4'd4, 4'd4, 4, "stock_4_4");
    endtask

    task automatic test_idle_vend_ignored;
        vend_done = 1'b1; vend_abort = 1'b1;
        tick();
        vend_done = 1'b0; vend_abort = 1'b0;
        tests++;
        if ({held, flags} !== 28'd0) begin
            fails++;
            $display("FAIL idle_vend got held=%h flags=%b exp 0", held, flags);
        end
    endtask

    task automatic test_hold;
        press(4'd5, 4'd2);
        for (int i = 0; i < 20; i++) tick();
        tests++;
        if (held !== {1'b1, 1'b1, 4'd5, 4'd2, 12'd250}) begin
            fails++;
            $display("FAIL hold_wait got %h exp %h", held, {1'b1, 1'b1, 4'd5, 4'd2, 12'd250});
        end
        row = 4'd5; col = 4'd5; enter_key = 1'b1;
        cfg_row = 4'd5; cfg_col = 4'd2; cfg_price = 12'd1; cfg_stock = 4'd0; cfg_we = 1'b1;
        tick();
        enter_key = 1'b0; cfg_we = 1'b0;
        tests++;
        if ({held, flags} !== {1'b1, 1'b1, 4'd5, 4'd2, 12'd250, 6'b110000}) begin
            fails++;
            $display("FAIL hold_ignore got held=%h flags=%b", held, flags);
        end
        abort_vend();
        press(4'd5, 4'd2);
        tests++;
        if (held !== {1'b1, 1'b1, 4'd5, 4'd2, 12'd250}) begin
            fails++;
            $display("FAIL hold_cfg_dropped got %h exp %h", held, {1'b1, 1'b1, 4'd5, 4'd2, 12'd250});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if ({held, flags} !== 28'd0) begin
            fails++;
            $display("FAIL reset_mid_hold got held=%h flags=%b exp 0", held, flags);
        end
        press(4'd1, 4'd1);
        tests++;
        if (held !== {1'b1, 1'b1, 4'd1, 4'd1, 12'd250}) begin
            fails++;
            $display("FAIL reset_restores_1_1 got %h exp %h", held, {1'b1, 1'b1, 4'd1, 4'd1, 12'd250});
        end
        abort_vend();
        drain(4'd2, 4'd3, 5, "restock_2_3");
    endtask

    initial begin
        test_reset();
        test_select_vend();
        test_stock_depletion();
        test_cfg_soldout();
        test_bad_addr();
        test_done_abort();
        test_idle_vend_ignored();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vm_selection_inventory.md
# vm_selection_inventory

Parametrised item-selection and inventory block for the vending machine; successor to the fixed 6x6 selection stage. It validates a row/column keypad selection against a per-slot price and stock table, then presents the selection to the payment/dispense logic and holds it until that logic completes or aborts the vend. A completed vend decrements the slot's stock. A service port reloads prices and stock at runtime.

## Interface
- ROWS, 6, number of slot rows (1..15)
- COLS, 6, number of slot columns (1..15)
- PRICE_W, 12, price width in cents
- STOCK_W, 4, per-slot stock counter width
- INIT_STOCK, 5, stock loaded into every slot on reset
- DEFAULT_PRICE, 250, price loaded into every slot on reset
- TIMEOUT_CYCLES, 1000, HOLD timeout length (used only when VM_SEL_TIMEOUT_EN is defined)
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- row  in  4  selected row; 1-based
- col  in  4  selected column; 1-based
- enter_key  in  1  selection strobe
- vend_done  in  1  payment/dispense side reports item delivered
- vend_abort  in  1  payment/dispense side cancels the vend
- cfg_we  in  1  service write strobe
- cfg_row, cfg_col  in  4 each  service target slot; 1-based
- cfg_price  in  PRICE_W  new price
- cfg_stock  in  STOCK_W  new stock count
- item_selection_valid  out  1  level; high while a selection is held
- dispense_row, dispense_col  out  4 each  held slot; 0 when not valid
- item_price  out  PRICE_W  held slot price; 0 when not valid
- dispense_pulse  out  1  one-cycle strobe on completed vend
- sel_error  out  1  one-cycle strobe on rejected selection or timeout
- error_code  out  2  00 none, 01 bad address, 10 sold out, 11 timeout; valid with sel_error
- busy  out  1  high whenever the FSM is not IDLE

## Operation
- The FSM has two states: IDLE and HOLD.
- Slot (r,c) is addressable iff 1<=r<=ROWS and 1<=c<=COLS.
- IDLE, enter_key=1, cfg_we=0:
  - An unaddressable slot gives sel_error with code 01.
  - Otherwise, stock==0 gives sel_error with code 10.
  - Otherwise the FSM latches row, col and price into the outputs, raises item_selection_valid and moves to HOLD.
- IDLE, cfg_we=1:
  - An addressable slot gets price and stock overwritten.
  - An unaddressable cfg target is ignored silently.
  - enter_key in the same cycle is ignored; cfg_we has priority.
- HOLD:
  - enter_key and cfg_we are ignored.
  - vend_done: the held slot's stock decrements by 1 (saturates at 0), dispense_pulse fires, outputs clear and the FSM returns to IDLE.
  - vend_abort: outputs clear and the FSM returns to IDLE. Stock is unchanged.
  - vend_done and vend_abort in the same cycle: vend_done wins.
- The price and stock array holds ROWS*COLS entries, indexed internally 0-based as (r-1)*COLS+(c-1).

## Timing
- Reset state: all outputs 0, FSM IDLE, every slot stock=INIT_STOCK and price=DEFAULT_PRICE. Reset in HOLD discards the selection with no decrement.
- Selection latency: enter_key sampled at edge N; item_selection_valid, busy, dispense_* and item_price are valid after edge N (one cycle). sel_error has the same one-cycle latency, lasts exactly 1 cycle, and the FSM stays IDLE.
- vend_done/vend_abort sampled at edge M:
  - item_selection_valid and busy fall after edge M.
  - dispense_pulse is high for the cycle after edge M.
  - The decremented stock is visible to an enter_key at edge M+1.
- A cfg write at edge N is visible to an enter_key at edge N+1.
- vend_done/vend_abort while IDLE are ignored.

## Configuration
- VM_SEL_TIMEOUT_EN defined:
  - A counter runs in HOLD and clears on entry.
  - If TIMEOUT_CYCLES edges pass in HOLD without vend_done or vend_abort, the FSM returns to IDLE, outputs clear, sel_error fires with code 11, and stock is unchanged.
  - vend_done on the timeout edge wins.
- VM_SEL_TIMEOUT_EN undefined: no counter; HOLD waits indefinitely and code 11 is never produced.

## Test plan
- Reset, then enter_key with row=2 col=3 -> next cycle: valid=1, dispense 2/3, item_price=250, busy=1. Then vend_done -> dispense_pulse for 1 cycle, valid=0, slot (2,3) stock=4.
- cfg_we (1,1) price=710 stock=1; select (1,1) and complete the vend; select (1,1) again -> sel_error, code 10, valid stays 0.
- enter_key with row=0 col=2, then row=7 col=1 (ROWS=6) -> sel_error with code 01 each time, no state change.
- Select (4,4), then apply vend_done and vend_abort in the same cycle -> dispense_pulse, stock decremented. Select again, vend_abort only -> no pulse, stock unchanged.
- In HOLD, apply enter_key (5,5) and cfg_we -> both ignored, held outputs unchanged. Assert reset mid-HOLD -> all outputs 0 next cycle, stock back to INIT_STOCK.
- With VM_SEL_TIMEOUT_EN and TIMEOUT_CYCLES=8: select, then idle 8 cycles -> sel_error code 11, valid=0, stock unchanged.
